// File: rtl/fifo_stream_reader.sv
// Read-side engine for the async FIFO: issues rd_en, absorbs the 1-cycle read latency in a
// 2-entry skid buffer and presents words on a valid/ready stream with a delivered-word count.
module fifo_stream_reader #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_r,
    input  logic              reset,
    input  logic              en,
    input  logic              underflow,
    input  logic [DATA_W-1:0] data_r,
    output logic              rd_en,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              busy,
    output logic [CNT_W-1:0]  word_cnt
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e            state_q, state_d;
    logic [1:0]        occ_q;
    logic              inflight_q;
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              pop;
    logic [1:0]        credit;
    logic [1:0]        tail_idx;

    assign valid_o = !reset && (occ_q != 2'd0);
    assign pop     = valid_o && ready_i;
    // occ + inflight never exceeds 2, so 2-bit arithmetic cannot wrap.
    assign credit  = occ_q + {1'b0, inflight_q} - {1'b0, pop};

    // State register
    always_ff @(posedge clk_r) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (en) state_d = StRun;
            StRun:   if (!en) state_d = StDrain;
            StDrain: begin
                if (en) begin
                    state_d = StRun;
                end else if (credit == 2'd0) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs; gated by reset so nothing leaks while reset is held
    always_comb begin
        rd_en    = !reset && (state_q == StRun) && en && !underflow && (credit < 2'd2);
        busy     = !reset && (state_q != StIdle);
        data_o   = reset ? '0 : head_q;
        word_cnt = reset ? '0 : cnt_q;
    end

    // Skid buffer: pop shifts tail into head, capture lands in the first free slot after pop
    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        tail_idx = occ_q - {1'b0, pop};
        if (pop) begin
            head_d = tail_q;
        end
        if (inflight_q) begin
            if (tail_idx == 2'd0) begin
                head_d = data_r;
            end else begin
                tail_d = data_r;
            end
        end
    end

    always_ff @(posedge clk_r) begin
        if (reset) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            cnt_q      <= '0;
        end else begin
            occ_q      <= credit;
            inflight_q <= rd_en;
            head_q     <= head_d;
            tail_q     <= tail_d;
            if (pop) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader: directed vector table, directed sequences and a
// randomized run checked every cycle against a queue-based reference model.
module tb_fifo_stream_reader;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;

    logic        clk_r = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        underflow = 1'b1;
    logic [7:0]  data_r = 8'h00;
    logic        rd_en;
    logic [7:0]  data_o;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic        busy;
    logic [15:0] word_cnt;

    fifo_stream_reader #(.DATA_W(8), .CNT_W(16)) dut (
        .clk_r    (clk_r),
        .reset    (reset),
        .en       (en),
        .underflow(underflow),
        .data_r   (data_r),
        .rd_en    (rd_en),
        .data_o   (data_o),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .busy     (busy),
        .word_cnt (word_cnt)
    );

    always #5 clk_r = ~clk_r;

    int n_pass = 0;
    int n_total = 0;

    // Reference model: source FIFO, skid contents, the word requested last cycle, mode, count
    logic [7:0]  src[$];
    logic [7:0]  sk[$];
    bit          pend_v = 1'b0;
    logic [7:0]  pend_w = 8'h00;
    int          m_mode = M_IDLE;
    logic [15:0] m_cnt = 16'h0000;
    logic        force_uf = 1'b0;

    // DUT samples from the latest cycle and observation bookkeeping
    logic        d_rd, d_valid, d_busy;
    logic [7:0]  d_data;
    logic [15:0] d_cnt;
    logic [7:0]  got[$];
    int          rd_count = 0;
    int          cur_run = 0;
    int          max_run = 0;
    int          cyc = 0;
    int          first_pop = -1;
    int          last_pop = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: got 0x%0h required 0x%0h", name, $time, act, exp);
    endtask

    task automatic cycle();
        logic e_rd, e_valid, e_busy, e_pop;
        logic [7:0]  e_data;
        logic [15:0] e_cnt;
        underflow = force_uf || (src.size() == 0);
        @(negedge clk_r);
        if (reset) begin
            e_rd = 0; e_valid = 0; e_busy = 0; e_cnt = 0; e_data = 0; e_pop = 0;
        end else begin
            e_valid = (sk.size() != 0);
            e_data  = e_valid ? sk[0] : 8'h00;
            e_pop   = e_valid && ready_i;
            e_rd    = (m_mode == M_RUN) && en && !underflow &&
                      (sk.size() + int'(pend_v) - int'(e_pop) < 2);
            e_busy  = (m_mode != M_IDLE);
            e_cnt   = m_cnt;
        end
        d_rd = rd_en; d_valid = valid_o; d_busy = busy; d_data = data_o; d_cnt = word_cnt;
        chk("rd_en", d_rd, e_rd);
        chk("valid_o", d_valid, e_valid);
        chk("busy", d_busy, e_busy);
        chk("word_cnt", d_cnt, e_cnt);
        if (e_valid || reset) chk("data_o", d_data, e_data);
        if (d_rd) begin rd_count++; cur_run++; if (cur_run > max_run) max_run = cur_run; end
        else cur_run = 0;
        if (d_valid && ready_i && !reset) begin
            got.push_back(d_data);
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
        end
        @(posedge clk_r);
        if (reset) begin
            sk.delete(); pend_v = 0; m_cnt = 0; m_mode = M_IDLE;
        end else begin
            if (e_pop) begin void'(sk.pop_front()); m_cnt++; end
            if (pend_v) sk.push_back(pend_w);
            pend_v = e_rd;
            if (e_rd) pend_w = src.pop_front();
            case (m_mode)
                M_IDLE:  if (en) m_mode = M_RUN;
                M_RUN:   if (!en) m_mode = M_DRAIN;
                default: if (en) m_mode = M_RUN;
                         else if (sk.size() == 0 && !pend_v) m_mode = M_IDLE;
            endcase
        end
        cyc++;
        #1;
        data_r = pend_v ? pend_w : 8'($urandom);
    endtask

    typedef struct {
        logic rst, en, rdy, uf;
        logic e_rd, e_valid;
        logic [7:0] e_data;
        logic e_busy;
        logic [15:0] e_cnt;
    } vec_t;
    vec_t vecs[15];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int held;
        // Reset, IDLE->RUN latency, 5 cycles of empty FIFO, then a single word 0xA5
        for (int i = 0; i < 3; i++) vecs[i] = '{1, 1, 1, 0, 0, 0, 8'h00, 0, 16'd0};
        vecs[3] = '{0, 1, 1, 1, 0, 0, 8'h00, 0, 16'd0};
        for (int i = 4; i < 9; i++) vecs[i] = '{0, 1, 1, 1, 0, 0, 8'h00, 1, 16'd0};
        vecs[9]  = '{0, 1, 1, 0, 1, 0, 8'h00, 1, 16'd0};
        vecs[10] = '{0, 1, 1, 0, 0, 0, 8'h00, 1, 16'd0};
        vecs[11] = '{0, 1, 1, 0, 0, 1, 8'hA5, 1, 16'd0};
        vecs[12] = '{0, 0, 1, 0, 0, 0, 8'h00, 1, 16'd1};
        vecs[13] = '{0, 0, 1, 0, 0, 0, 8'h00, 1, 16'd1};
        vecs[14] = '{0, 0, 1, 0, 0, 0, 8'h00, 0, 16'd1};

        src.push_back(8'hA5);
        @(posedge clk_r); #1;
        for (int i = 0; i < 15; i++) begin
            reset = vecs[i].rst; en = vecs[i].en; ready_i = vecs[i].rdy; force_uf = vecs[i].uf;
            cycle();
            chk("tbl_rd_en", d_rd, vecs[i].e_rd);
            chk("tbl_valid", d_valid, vecs[i].e_valid);
            chk("tbl_data", d_data, vecs[i].e_data);
            chk("tbl_busy", d_busy, vecs[i].e_busy);
            chk("tbl_cnt", d_cnt, vecs[i].e_cnt);
        end

        // Streaming: 16 words at full rate
        for (int i = 1; i <= 16; i++) src.push_back(8'(i));
        got.delete(); max_run = 0; cur_run = 0; first_pop = -1;
        en = 1; ready_i = 1; force_uf = 0;
        for (int k = 0; k < 22; k++) cycle();
        chk("stream_rd_run", max_run, 16);
        chk("stream_count", got.size(), 16);
        for (int i = 0; i < got.size(); i++) chk("stream_word", got[i], i + 1);
        chk("stream_no_gaps", last_pop - first_pop, 15);
        chk("stream_word_cnt", d_cnt, 17);

        // Backpressure: stall from idle, two reads only, head held
        en = 0;
        for (int k = 0; k < 3; k++) cycle();
        for (int i = 1; i <= 16; i++) src.push_back(8'(i));
        got.delete(); rd_count = 0;
        en = 1; ready_i = 0;
        for (int k = 0; k < 12; k++) cycle();
        chk("bp_rd_count", rd_count, 2);
        chk("bp_valid_held", d_valid, 1);
        chk("bp_data_held", d_data, 8'h01);
        ready_i = 1;
        for (int k = 0; k < 25; k++) cycle();
        chk("bp_count", got.size(), 16);
        for (int i = 0; i < got.size(); i++) chk("bp_word", got[i], i + 1);

        // Drain: drop en mid-stream, every buffered/in-flight word still delivered
        for (int i = 0; i < 8; i++) src.push_back(8'h31 + 8'(i));
        for (int k = 0; k < 4; k++) cycle();
        en = 0;
        held = sk.size() + int'(pend_v);
        got.delete(); rd_count = 0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (!d_busy) break;
        end
        chk("drain_idle", d_busy, 0);
        chk("drain_words", got.size(), held);
        chk("drain_no_rd", rd_count, 0);
        src.delete();

        // Counter wrap
        en = 1; ready_i = 1;
        for (int k = 0; k < 70000 && m_cnt != 16'hFFFF; k++) begin
            if (src.size() < 4) src.push_back(8'($urandom));
            cycle();
        end
        ready_i = 0;
        cycle();
        chk("wrap_ffff", d_cnt, 16'hFFFF);
        ready_i = 1;
        cycle();
        chk("wrap_pop_valid", d_valid, 1);
        cycle();
        chk("wrap_zero", d_cnt, 16'h0000);

        // Mid-operation reset with a full buffer
        ready_i = 0;
        for (int k = 0; k < 4; k++) cycle();
        chk("mid_full_valid", d_valid, 1);
        reset = 1;
        cycle();
        chk("mid_rst_valid", d_valid, 0);
        reset = 0; en = 0;
        cycle();
        chk("mid_post_valid", d_valid, 0);
        chk("mid_post_cnt", d_cnt, 0);
        chk("mid_post_busy", d_busy, 0);
        src.delete();

        // Randomized run against the model
        for (int k = 0; k < 3000; k++) begin
            reset    = ($urandom_range(0, 199) == 0);
            en       = ($urandom_range(0, 9) != 0);
            ready_i  = ($urandom_range(0, 2) != 0);
            force_uf = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1 && src.size() < 20) src.push_back(8'($urandom));
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
